// File: rtl/hcms29xx_pkg.sv
// Shared types and constants for the HCMS-29xx display-side receiver.
package hcms29xx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  localparam logic HCMS_DATA_REGISTER    = 1'b0;
  localparam logic HCMS_COMMAND_REGISTER = 1'b1;

  localparam int NUM_COLS_DEFAULT = 20;

  // Control-word layout: bit 7 picks the register, bits [6:0] are its payload.
  localparam int CTRL_W           = 7;
  localparam int CTRL_SEL_BIT     = 7;
  localparam int CTRL_SLEEP_N_BIT = 6;
  localparam int CTRL_PEAK_LSB    = 4;
  localparam int CTRL_BRIGHT_LSB  = 0;

endpackage

// File: rtl/hcms29xx_if.sv
// The five HCMS-29xx serial pins; the transmitter drives them, the receiver listens.
interface hcms29xx_if;
  logic i_hcms_data;
  logic i_hcms_clock;
  logic i_hcms_regsel;
  logic i_hcms_ncs;
  logic i_hcms_nreset;

  modport master (
    output i_hcms_data, i_hcms_clock, i_hcms_regsel, i_hcms_ncs, i_hcms_nreset
  );

  modport slave (
    input i_hcms_data, i_hcms_clock, i_hcms_regsel, i_hcms_ncs, i_hcms_nreset
  );
endinterface

// File: rtl/hcms29xx_pin_sync.sv
// N-stage synchronizer for one asynchronous pin, plus a history flop for edge detection.
module hcms_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_sync,
  output logic o_prev
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_pin};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];
  assign o_prev = prev_q;

endmodule

// File: rtl/hcms29xx_receiver.sv
// HCMS-29xx display emulator: decodes dot data into a double-buffered column
// memory and control words into registers, flagging malformed transfers.
module hcms29xx_receiver
  import hcms29xx_pkg::*;
#(
  parameter int  NUM_COLS    = NUM_COLS_DEFAULT,
  parameter int  SYNC_STAGES = 2,
  localparam int AW          = $clog2(NUM_COLS)
) (
  input  logic              i_CLK,
  input  logic              i_nReset,
  hcms29xx_if.slave         hcms,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [7:0]        o_rd_data,
  output logic              o_frame_valid,
  output logic [CTRL_W-1:0] o_ctrl0,
  output logic [CTRL_W-1:0] o_ctrl1,
  output logic              o_busy,
  output logic              o_err_partial,
  output logic              o_err_overflow,
  input  logic              i_err_clr
);

  localparam logic [AW-1:0] LAST_COL = AW'(NUM_COLS - 1);

  logic       din_s, sclk_s, sclk_p, rs_s, ncs_s, ncs_p, nrst_s;
  logic [2:0] unused_prev;

  hcms_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk(i_CLK), .rst_n(i_nReset), .i_pin(hcms.i_hcms_data), .o_sync(din_s), .o_prev(unused_prev[0]));
  hcms_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(i_CLK), .rst_n(i_nReset), .i_pin(hcms.i_hcms_clock), .o_sync(sclk_s), .o_prev(sclk_p));
  hcms_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_rs (
    .clk(i_CLK), .rst_n(i_nReset), .i_pin(hcms.i_hcms_regsel), .o_sync(rs_s), .o_prev(unused_prev[1]));
  // Chip enable idles high, so its chain resets high to avoid a false fall after reset.
  hcms_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(i_CLK), .rst_n(i_nReset), .i_pin(hcms.i_hcms_ncs), .o_sync(ncs_s), .o_prev(ncs_p));
  hcms_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_nrst (
    .clk(i_CLK), .rst_n(i_nReset), .i_pin(hcms.i_hcms_nreset), .o_sync(nrst_s), .o_prev(unused_prev[2]));

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_p;
  assign ncs_fall  = ~ncs_s & ncs_p;
  assign ncs_rise  = ncs_s & ~ncs_p;

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              wrap_q, wrap_d;
  logic              got_q, got_d;
  logic              rs_q, rs_d;
  logic [7:0]        shadow_q [NUM_COLS];
  logic [7:0]        shadow_d [NUM_COLS];
  logic [7:0]        disp_q   [NUM_COLS];
  logic [7:0]        disp_d   [NUM_COLS];
  logic [CTRL_W-1:0] ctrl0_q, ctrl0_d, ctrl1_q, ctrl1_d;
  logic              fv_q, fv_d;
  logic              perr_q, perr_d, oerr_q, oerr_d;
  logic              perr_set, oerr_set;
  logic [7:0]        rd_data_q, rd_data_d;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    wrap_d   = wrap_q;
    got_d    = got_q;
    rs_d     = rs_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    ctrl0_d  = ctrl0_q;
    ctrl1_d  = ctrl1_q;
    fv_d     = 1'b0;
    perr_set = 1'b0;
    oerr_set = 1'b0;

    if (!nrst_s) begin
      // Display reset drops pending column writes and forces sleep; the shown frame stays.
      state_d  = IDLE;
      shadow_d = disp_q;
      ctrl0_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_d = SHIFT;
            sr_d    = '0;
            cnt_d   = '0;
            ptr_d   = '0;
            wrap_d  = 1'b0;
            got_d   = 1'b0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            sr_d  = {sr_q[6:0], din_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              got_d = 1'b1;
              if (rs_s == HCMS_DATA_REGISTER) begin
                shadow_d[ptr_q] = sr_d;
                if (wrap_q) oerr_set = 1'b1;
                if (ptr_q == LAST_COL) begin
                  ptr_d  = '0;
                  wrap_d = 1'b1;
                end else begin
                  ptr_d = ptr_q + AW'(1);
                end
              end
            end
          end
          // A same-cycle clock rise is shifted above before the commit is taken.
          if (ncs_rise) begin
            state_d = COMMIT;
            rs_d    = rs_s;
          end
        end
        COMMIT: begin
          state_d = IDLE;
          if (cnt_q != 3'd0) perr_set = 1'b1;
          if (rs_q == HCMS_DATA_REGISTER) begin
            if (got_q) begin
              disp_d = shadow_q;
              fv_d   = 1'b1;
            end
          end else if (got_q && cnt_q == 3'd0) begin
            if (sr_q[CTRL_SEL_BIT]) ctrl1_d = sr_q[CTRL_W-1:0];
            else                    ctrl0_d = sr_q[CTRL_W-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end

    perr_d = i_err_clr ? 1'b0 : (perr_q | perr_set);
    oerr_d = i_err_clr ? 1'b0 : (oerr_q | oerr_set);

    rd_data_d = '0;
    if (int'(i_rd_addr) < NUM_COLS) rd_data_d = disp_q[i_rd_addr];
  end

  // NOTE: both column buffers are flop arrays, so they reset to a known blank frame.
  always_ff @(posedge i_CLK or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      wrap_q    <= 1'b0;
      got_q     <= 1'b0;
      rs_q      <= 1'b0;
      shadow_q  <= '{default: '0};
      disp_q    <= '{default: '0};
      ctrl0_q   <= '0;
      ctrl1_q   <= '0;
      fv_q      <= 1'b0;
      perr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      wrap_q    <= wrap_d;
      got_q     <= got_d;
      rs_q      <= rs_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      ctrl0_q   <= ctrl0_d;
      ctrl1_q   <= ctrl1_d;
      fv_q      <= fv_d;
      perr_q    <= perr_d;
      oerr_q    <= oerr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data      = rd_data_q;
  assign o_frame_valid  = fv_q;
  assign o_ctrl0        = ctrl0_q;
  assign o_ctrl1        = ctrl1_q;
  assign o_busy         = (state_q == SHIFT);
  assign o_err_partial  = perr_q;
  assign o_err_overflow = oerr_q;

endmodule
